switch_debounce: RTL and testbench
==================================

# switch_debounce

Conditions the raw board slide-switch bank before it reaches the mode-selection stage. Every bit is double-flop synchronised and debounced against a shared millisecond-scale tick. The block presents a glitch-free registered switch word, a one-cycle change strobe and a power-up valid flag. The mode decoder consumes `sw_db` directly as its 16-bit switch input.

## Interface
- `WIDTH`, 16, number of switch channels
- `TICK_DIV`, 50000, clk cycles per debounce tick (1 ms at 50 MHz); must be ≥ 2
- `STABLE_TICKS`, 10, consecutive ticks a new level must persist before acceptance; must be ≥ 2

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `sw_raw`  in  WIDTH  asynchronous switch pins
- `sw_db`  out  WIDTH  debounced switch word, registered
- `sw_changed`  out  1  one-cycle pulse in the cycle `sw_db` takes a new value
- `sw_valid`  out  1  high once STABLE_TICKS ticks have elapsed since reset; sticky
- `sw_rise`  out  WIDTH  per-bit 0→1 update pulse (only with `SWDB_EDGE_EN`)
- `sw_fall`  out  WIDTH  per-bit 1→0 update pulse (only with `SWDB_EDGE_EN`)

## Operation
- Synchroniser: two flops per bit. Reset value 0. The output is `sync[i]`.
- Prescaler: counter `0..TICK_DIV-1`, wraps to 0. `tick` is high for one cycle when count = TICK_DIV-1.
- Per channel, there is a counter `cnt` of width clog2(STABLE_TICKS). It has two states, IDLE (cnt=0, `sync==sw_db`) and COUNT:
  - `sync[i]==sw_db[i]`: `cnt` cleared on that cycle, regardless of `tick`. A bounce therefore restarts the window.
  - Mismatch and `tick` with `cnt < STABLE_TICKS-1`: `cnt` increments.
  - Mismatch and `tick` with `cnt == STABLE_TICKS-1`: `sw_db[i]` ← `sync[i]`, `cnt` ← 0.
  - Mismatch without `tick`: hold.
- `sw_changed` = registered OR of all per-bit update enables. It is high in the cycle after the update edge, aligned with the new `sw_db`. Several bits updating on the same tick produce a single pulse.
- `sw_valid`: a tick counter saturates at STABLE_TICKS; the flag is set on the STABLE_TICKS-th tick after reset.
  - Downstream ignores `sw_db` while `sw_valid`=0.
  - Channels that are high at power-up reach `sw_db` on that same tick edge.
- Reset mid-count: all state returns to reset values immediately. A full window is required afterwards.

## Timing
- Reset values: `sw_db`=0, `sw_changed`=0, `sw_valid`=0, `sw_rise`=`sw_fall`=0, prescaler=0, all `cnt`=0, synchroniser=0.
- Latency, with `sync[i]` first differing at cycle t: `sw_db[i]` updates at the edge closing the STABLE_TICKS-th tick cycle ≥ t.
  - Bounds: t+(STABLE_TICKS-1)·TICK_DIV+1 ≤ update ≤ t+STABLE_TICKS·TICK_DIV.
  - Measured from the `sw_raw` change, add 2 cycles for the synchroniser.
- A tick in the same cycle the mismatch first appears counts as tick 1.
- Pulses shorter than (STABLE_TICKS-1)·TICK_DIV cycles never reach `sw_db`.

## Configuration
- `SWDB_EDGE_EN` defined:
  - `sw_rise[i]` / `sw_fall[i]` pulse for one cycle, coincident with `sw_changed`, for each bit that updated 0→1 / 1→0.
- `SWDB_EDGE_EN` undefined:
  - Both ports remain and are tied to 0.
  - No edge registers are synthesised.

## Structure
- Shared package `switch_pkg`:
  - `SW_WIDTH` = 16
  - default `TICK_DIV` and `STABLE_TICKS` constants
  - typedef `sw_word_t` (logic [SW_WIDTH-1:0]), shared with the mode decoder
- One sub-module, `switch_db_chan`: the synchroniser, counter and output flop for one bit, with `tick` as input and `upd` as output. It is instantiated WIDTH times via generate.
- The top holds the prescaler, the valid counter, the `sw_changed` OR and the optional edge logic.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `STABLE_TICKS`=3.
- Reset with `sw_raw`=16'h0000: all outputs 0 during reset; `sw_valid` rises 12 cycles after release; `sw_changed` never pulses.
- `sw_raw` 0000→0001 held: `sw_db`=0001 within 2+9..2+12 cycles; exactly one `sw_changed` pulse; no pulse afterwards.
- Bit 1 toggling every 5 cycles for 60 cycles, then held at 1: `sw_db[1]` stays 0 throughout the bounce and updates only one full window after the final edge.
- `sw_raw` 0000→007F in one cycle: all seven bits update on the same edge, `sw_db`=007F, a single `sw_changed` pulse.
- `rst_n` asserted with `cnt`=2 pending on bit 0: `sw_db` returns to 0 and `sw_valid` clears; after release, the update takes the full window again.
- With `SWDB_EDGE_EN`, 0000→0003→0001: `sw_rise`=0003 pulses once, then `sw_fall`=0002 pulses once. Without the macro, both stay 0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch-bank types and default debounce timing, also used by the mode decoder.
package switch_pkg;
    localparam int SW_WIDTH         = 16;
    localparam int TICK_DIV_DEF     = 50000;
    localparam int STABLE_TICKS_DEF = 10;

    typedef logic [SW_WIDTH-1:0] sw_word_t;
endpackage

// File: rtl/switch_db_chan.sv
// One switch channel: 2-flop synchroniser, stable-tick counter and debounced output flop.
// Latency: STABLE_TICKS ticks after the synchronised level differs; no backpressure.
module switch_db_chan
    import switch_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic tick_i,
    output logic db_o,
    output logic upd_o
);
    localparam int             CW       = $clog2(STABLE_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd;

    // Any cycle where the synchronised level agrees with the output restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        upd   = 1'b0;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                upd   = 1'b1;
                db_d  = s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_o  = db_q;
    assign upd_o = upd;
endmodule

// File: rtl/switch_debounce.sv
// Debounced slide-switch bank: shared tick prescaler, per-bit channels, change strobe, power-up valid.
// Optional SWDB_EDGE_EN adds registered per-bit rise/fall pulses; otherwise those ports are tied to 0.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic             sw_changed,
    output logic             sw_valid,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int VW = $clog2(STABLE_TICKS + 1);

    logic [PW-1:0]    presc_q;
    logic [VW-1:0]    vcnt_q;
    logic             valid_q;
    logic             changed_q;
    logic             tick;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] upd;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            vcnt_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            presc_q   <= tick ? '0 : presc_q + PW'(1);
            changed_q <= |upd;
            if (tick && (vcnt_q != VW'(STABLE_TICKS))) begin
                vcnt_q <= vcnt_q + VW'(1);
                if (vcnt_q == VW'(STABLE_TICKS - 1)) begin
                    valid_q <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        switch_db_chan #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_i (sw_raw[i]),
            .tick_i(tick),
            .db_o  (db[i]),
            .upd_o (upd[i])
        );
    end

`ifdef SWDB_EDGE_EN
    logic [WIDTH-1:0] rise_q, fall_q;

    // An update always flips the bit, so the old value alone gives the direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= upd & ~db;
            fall_q <= upd & db;
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif

    assign sw_db      = db;
    assign sw_changed = changed_q;
    assign sw_valid   = valid_q;
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_switch_debounce;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic [15:0] sw_db;
    logic        sw_changed;
    logic        sw_valid;
    logic [15:0] sw_rise;
    logic [15:0] sw_fall;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] rise_acc, fall_acc;
    int          rise_cnt, fall_cnt;

    switch_debounce #(
        .WIDTH       (16),
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_db     (sw_db),
        .sw_changed(sw_changed),
        .sw_valid  (sw_valid),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // One clock; returns at the following falling edge where outputs are sampled and inputs driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_acc();
        rise_acc = '0;
        fall_acc = '0;
        rise_cnt = 0;
        fall_cnt = 0;
    endtask

    // Runs max_n cycles; n is the first cycle sw_db equals exp (0 if never), pulses counts sw_changed.
    task automatic run_until(input logic [15:0] exp, input int max_n, output int n, output int pulses);
        n      = 0;
        pulses = 0;
        for (int i = 1; i <= max_n; i++) begin
            step();
            if (n == 0 && sw_db == exp) n = i;
            if (sw_changed) pulses++;
            rise_acc |= sw_rise;
            fall_acc |= sw_fall;
            if (|sw_rise) rise_cnt++;
            if (|sw_fall) fall_cnt++;
        end
    endtask

    initial begin
        int n, p, first_valid, chg;
        logic stuck;

        rst_n  = 1'b0;
        sw_raw = 16'h0000;
        clr_acc();

        // Reset state
        step();
        step();
        chk("rst_db", sw_db, 0);
        chk("rst_changed", sw_changed, 0);
        chk("rst_valid", sw_valid, 0);
        chk("rst_edges", sw_rise | sw_fall, 0);
        rst_n = 1'b1;

        first_valid = 0;
        chg = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (first_valid == 0 && sw_valid) first_valid = i;
            if (sw_changed) chg++;
        end
        chk("valid_latency", first_valid, 12);
        chk("idle_no_change", chg, 0);

        // Single bit rise
        sw_raw = 16'h0001;
        run_until(16'h0001, 30, n, p);
        chk("b0_lat_lo", (n >= 11), 1);
        chk("b0_lat_hi", (n <= 14), 1);
        chk("b0_db", sw_db, 16'h0001);
        chk("b0_pulses", p, 1);

        // Bounce on bit 1: 5-cycle segments never reach sw_db
        stuck = 1'b0;
        sw_raw = 16'h0003;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (sw_db[1]) stuck = 1'b1;
            if (i % 5 == 0) sw_raw[1] = ~sw_raw[1];
        end
        chk("bounce_filtered", stuck, 0);
        sw_raw = 16'h0003;
        run_until(16'h0003, 30, n, p);
        chk("bounce_lat_lo", (n >= 11), 1);
        chk("bounce_lat_hi", (n <= 14), 1);
        chk("bounce_pulses", p, 1);

        // Seven bits at once
        sw_raw = 16'h0000;
        run_until(16'h0000, 30, n, p);
        chk("clr_db", sw_db, 16'h0000);
        sw_raw = 16'h007F;
        run_until(16'h007F, 30, n, p);
        chk("multi_db", sw_db, 16'h007F);
        chk("multi_pulses", p, 1);
        chk("multi_lat_lo", (n >= 11), 1);

        // Reset with a pending fall on bit 0 (two ticks counted after 10 cycles)
        sw_raw = 16'h007E;
        for (int i = 0; i < 10; i++) step();
        chk("pend_db", sw_db, 16'h007F);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_db", sw_db, 0);
        chk("mid_rst_valid", sw_valid, 0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) step();
        chk("post_rst_db_e11", sw_db, 0);
        step();
        chk("post_rst_db_e12", sw_db, 16'h007E);
        chk("post_rst_valid_e12", sw_valid, 1);
        chk("post_rst_chg_e12", sw_changed, 1);
        step();
        chk("post_rst_chg_e13", sw_changed, 0);

        // Edge pulses
        sw_raw = 16'h0000;
        run_until(16'h0000, 30, n, p);
        clr_acc();
        sw_raw = 16'h0003;
        run_until(16'h0003, 30, n, p);
        chk("edge_up_db", sw_db, 16'h0003);
`ifdef SWDB_EDGE_EN
        chk("rise_val", rise_acc, 16'h0003);
        chk("rise_cnt", rise_cnt, 1);
        chk("rise_nofall", fall_cnt, 0);
`else
        chk("rise_tied", rise_acc | fall_acc, 0);
`endif
        clr_acc();
        sw_raw = 16'h0001;
        run_until(16'h0001, 30, n, p);
        chk("edge_dn_db", sw_db, 16'h0001);
`ifdef SWDB_EDGE_EN
        chk("fall_val", fall_acc, 16'h0002);
        chk("fall_cnt", fall_cnt, 1);
        chk("fall_norise", rise_cnt, 0);
`else
        chk("fall_tied", rise_acc | fall_acc, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
